// File: rtl/note_sequencer.sv
// Melody recorder/player: timestamps changes on the live one-hot note bus into
// on-chip memory as (note, duration) events and replays them onto note_out.
module note_sequencer #(
    parameter int DEPTH    = 64,
    parameter int TICK_DIV = 500000,
    parameter int DUR_W    = 12
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [31:0]            live_note,
    input  logic                   rec_start,
    input  logic                   play_start,
    input  logic                   stop,
    output logic [31:0]            note_out,
    output logic                   recording,
    output logic                   playing,
    output logic [$clog2(DEPTH):0] event_count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int EW = 32 + DUR_W;

    typedef enum logic [1:0] {IDLE, RECORD, LOAD, PLAY} state_t;

    state_t           state, state_d;
    logic [31:0]      note_d;
    logic [31:0]      cur_note, cur_note_d;
    logic [DUR_W-1:0] dur, dur_d;
    logic [TW-1:0]    tick, tick_d;
    logic [AW-1:0]    wr_ptr, wr_ptr_d;
    logic [CW-1:0]    rd_ptr, rd_ptr_d;
    logic [CW-1:0]    count_d;
    logic             overflow_d;
    logic             phase, phase_d;
    logic             we;
    logic             commit;
    logic             tick_wrap;
    logic [31:0]      snote;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    ram_q;
    logic [31:0]      ram_note;
    logic [DUR_W-1:0] ram_dur;

    assign snote     = ((live_note & (live_note - 32'd1)) == '0) ? live_note : '0;
    assign ram_note  = ram_q[EW-1:DUR_W];
    assign ram_dur   = ram_q[DUR_W-1:0];
    assign tick_wrap = (tick == TW'(TICK_DIV - 1));
    assign recording = (state == RECORD);
    assign playing   = (state == LOAD) || (state == PLAY);

    always_ff @(posedge CLOCK_50) begin
        if (we)
            mem[wr_ptr] <= {cur_note, dur};
        ram_q <= mem[rd_ptr[AW-1:0]];
    end

    always_comb begin
        state_d    = state;
        note_d     = note_out;
        cur_note_d = cur_note;
        dur_d      = dur;
        tick_d     = tick;
        wr_ptr_d   = wr_ptr;
        rd_ptr_d   = rd_ptr;
        count_d    = event_count;
        overflow_d = overflow;
        phase_d    = phase;
        we         = 1'b0;
        commit     = 1'b0;

        case (state)
            IDLE: begin
                note_d = snote;
                if (!stop && rec_start) begin
                    state_d    = RECORD;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    wr_ptr_d   = '0;
                    cur_note_d = snote;
                    dur_d      = '0;
                    tick_d     = '0;
                end else if (!stop && play_start && event_count != '0) begin
                    state_d  = LOAD;
                    rd_ptr_d = '0;
                    phase_d  = 1'b0;
                end
            end

            RECORD: begin
                note_d = snote;
                if (stop || snote != cur_note) begin
                    // zero-duration segments are glitches and never reach memory
                    commit     = (dur != '0) && (event_count < CW'(DEPTH));
                    cur_note_d = snote;
                    dur_d      = '0;
                    tick_d     = '0;
                    if (stop)
                        state_d = IDLE;
                end else if (tick_wrap) begin
                    tick_d = '0;
                    if (dur != '1)
                        dur_d = dur + 1'b1;
                end else begin
                    tick_d = tick + 1'b1;
                end
                if (commit) begin
                    we      = 1'b1;
                    count_d = event_count + 1'b1;
                    if (event_count == CW'(DEPTH - 1)) begin
                        overflow_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        wr_ptr_d = wr_ptr + 1'b1;
                    end
                end
            end

            LOAD: begin
                // phase 0 lets ram_q capture mem[rd_ptr]; phase 1 applies it
                if (stop) begin
                    note_d  = '0;
                    state_d = IDLE;
                end else if (!phase) begin
                    phase_d = 1'b1;
                end else if (rd_ptr == event_count) begin
                    note_d  = '0;
                    state_d = IDLE;
                end else begin
                    note_d  = ram_note;
                    tick_d  = TW'(1);
                    dur_d   = '0;
                    phase_d = 1'b0;
                    state_d = PLAY;
                end
            end

            PLAY: begin
                // counting starts at 1 so the two LOAD cycles complete dur*TICK_DIV+1
                if (stop) begin
                    note_d  = '0;
                    state_d = IDLE;
                end else if (tick_wrap && dur == ram_dur - 1'b1) begin
                    rd_ptr_d = rd_ptr + 1'b1;
                    phase_d  = 1'b0;
                    state_d  = LOAD;
                end else if (tick_wrap) begin
                    tick_d = '0;
                    dur_d  = dur + 1'b1;
                end else begin
                    tick_d = tick + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            note_out    <= '0;
            cur_note    <= '0;
            dur         <= '0;
            tick        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            event_count <= '0;
            overflow    <= 1'b0;
            phase       <= 1'b0;
        end else begin
            state       <= state_d;
            note_out    <= note_d;
            cur_note    <= cur_note_d;
            dur         <= dur_d;
            tick        <= tick_d;
            wr_ptr      <= wr_ptr_d;
            rd_ptr      <= rd_ptr_d;
            event_count <= count_d;
            overflow    <= overflow_d;
            phase       <= phase_d;
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4, DEPTH=4, DUR_W=3.
module tb_note_sequencer;
    logic        clk;
    logic        reset;
    logic [31:0] live_note;
    logic        rec_start;
    logic        play_start;
    logic        stop;
    logic [31:0] note_out;
    logic        recording;
    logic        playing;
    logic [2:0]  event_count;
    logic        overflow;

    int passed = 0;
    int total  = 0;

    note_sequencer #(.DEPTH(4), .TICK_DIV(4), .DUR_W(3)) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .live_note  (live_note),
        .rec_start  (rec_start),
        .play_start (play_start),
        .stop       (stop),
        .note_out   (note_out),
        .recording  (recording),
        .playing    (playing),
        .event_count(event_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        total++; if (note_out !== 32'h0) $display("FAIL reset_note: got %h, expected 0", note_out); else passed++;
        total++; if (recording !== 1'b0) $display("FAIL reset_recording: got %b, expected 0", recording); else passed++;
        total++; if (playing !== 1'b0) $display("FAIL reset_playing: got %b, expected 0", playing); else passed++;
        total++; if (event_count !== 3'd0) $display("FAIL reset_count: got %0d, expected 0", event_count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b, expected 0", overflow); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_passthrough();
        live_note = 32'h8;
        step(1);
        total++; if (note_out !== 32'h8) $display("FAIL pass_onehot: got %h, expected 8", note_out); else passed++;
        live_note = 32'h6;
        step(1);
        total++; if (note_out !== 32'h0) $display("FAIL pass_multi: got %h, expected 0", note_out); else passed++;
        live_note = 32'h8000_0000;
        step(1);
        total++; if (note_out !== 32'h8000_0000) $display("FAIL pass_msb: got %h, expected 80000000", note_out); else passed++;
        live_note = 32'h0;
        step(1);
    endtask

    task automatic test_play_empty(input string tag);
        play_start = 1'b1;
        step(1);
        play_start = 1'b0;
        total++; if (playing !== 1'b0) $display("FAIL %s_playing0: got %b, expected 0", tag, playing); else passed++;
        step(2);
        total++; if (playing !== 1'b0) $display("FAIL %s_playing2: got %b, expected 0", tag, playing); else passed++;
        total++; if (note_out !== 32'h0) $display("FAIL %s_note: got %h, expected 0", tag, note_out); else passed++;
    endtask

    // Each segment: the cycle the note first appears, then n counted cycles.
    task automatic test_record();
        rec_start = 1'b1;
        live_note = 32'h1;
        step(1);
        rec_start = 1'b0;
        total++; if (recording !== 1'b1) $display("FAIL rec_active: got %b, expected 1", recording); else passed++;
        total++; if (event_count !== 3'd0) $display("FAIL rec_cnt0: got %0d, expected 0", event_count); else passed++;
        step(8);
        live_note = 32'h4;
        step(1);
        total++; if (note_out !== 32'h4) $display("FAIL rec_passthru: got %h, expected 4", note_out); else passed++;
        total++; if (event_count !== 3'd1) $display("FAIL rec_cnt1: got %0d, expected 1", event_count); else passed++;
        step(13);
        live_note = 32'h1;
        step(1);
        total++; if (event_count !== 3'd2) $display("FAIL rec_cnt2: got %0d, expected 2", event_count); else passed++;
        step(2);
        live_note = 32'h10;
        step(1);
        total++; if (event_count !== 3'd2) $display("FAIL rec_glitch: got %0d, expected 2", event_count); else passed++;
        step(4);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        live_note = 32'h0;
        total++; if (event_count !== 3'd3) $display("FAIL rec_cnt3: got %0d, expected 3", event_count); else passed++;
        total++; if (recording !== 1'b0) $display("FAIL rec_stopped: got %b, expected 0", recording); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rec_overflow: got %b, expected 0", overflow); else passed++;
    endtask

    task automatic test_playback();
        logic [31:0] exp_note;
        logic        exp_play;
        play_start = 1'b1;
        live_note  = 32'h0;
        step(1);
        play_start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) step(1);
            if (k < 2)        exp_note = 32'h0;
            else if (k <= 10) exp_note = 32'h1;
            else if (k <= 23) exp_note = 32'h4;
            else if (k <= 28) exp_note = 32'h10;
            else              exp_note = 32'h0;
            exp_play = (k <= 28);
            total++; if (note_out !== exp_note) $display("FAIL play_note[%0d]: got %h, expected %h", k, note_out, exp_note); else passed++;
            total++; if (playing !== exp_play) $display("FAIL play_flag[%0d]: got %b, expected %b", k, playing, exp_play); else passed++;
            live_note = (k % 2 == 1) ? 32'h0000_0100 : 32'h8000_0000;
        end
        live_note = 32'h0;
        step(1);
        total++; if (event_count !== 3'd3) $display("FAIL play_cnt_kept: got %0d, expected 3", event_count); else passed++;
    endtask

    task automatic test_simultaneous();
        stop       = 1'b1;
        play_start = 1'b1;
        step(1);
        stop       = 1'b0;
        play_start = 1'b0;
        total++; if (playing !== 1'b0) $display("FAIL stop_play_idle: got %b, expected 0", playing); else passed++;
        total++; if (recording !== 1'b0) $display("FAIL stop_play_rec: got %b, expected 0", recording); else passed++;

        play_start = 1'b1;
        step(1);
        play_start = 1'b0;
        step(11);
        total++; if (note_out !== 32'h4) $display("FAIL stop_ev1_note: got %h, expected 4", note_out); else passed++;
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        total++; if (note_out !== 32'h0) $display("FAIL stop_ev1_zero: got %h, expected 0", note_out); else passed++;
        total++; if (playing !== 1'b0) $display("FAIL stop_ev1_playing: got %b, expected 0", playing); else passed++;
        total++; if (event_count !== 3'd3) $display("FAIL stop_ev1_cnt: got %0d, expected 3", event_count); else passed++;

        play_start = 1'b1;
        step(1);
        play_start = 1'b0;
        step(2);
        total++; if (note_out !== 32'h1) $display("FAIL restart_ev0: got %h, expected 1", note_out); else passed++;
        stop = 1'b1;
        step(1);
        stop = 1'b0;

        rec_start  = 1'b1;
        play_start = 1'b1;
        step(1);
        rec_start  = 1'b0;
        play_start = 1'b0;
        total++; if (recording !== 1'b1) $display("FAIL rec_play_rec: got %b, expected 1", recording); else passed++;
        total++; if (playing !== 1'b0) $display("FAIL rec_play_play: got %b, expected 0", playing); else passed++;
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        total++; if (event_count !== 3'd0) $display("FAIL rec_play_cnt: got %0d, expected 0", event_count); else passed++;
    endtask

    task automatic test_saturation();
        rec_start = 1'b1;
        live_note = 32'h2;
        step(1);
        rec_start = 1'b0;
        step(40);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        live_note = 32'h0;
        total++; if (event_count !== 3'd1) $display("FAIL sat_cnt: got %0d, expected 1", event_count); else passed++;
        play_start = 1'b1;
        step(1);
        play_start = 1'b0;
        step(2);
        total++; if (note_out !== 32'h2) $display("FAIL sat_first: got %h, expected 2", note_out); else passed++;
        step(28);
        total++; if (note_out !== 32'h2) $display("FAIL sat_last: got %h, expected 2", note_out); else passed++;
        total++; if (playing !== 1'b1) $display("FAIL sat_playing: got %b, expected 1", playing); else passed++;
        step(1);
        total++; if (note_out !== 32'h0) $display("FAIL sat_end: got %h, expected 0", note_out); else passed++;
        total++; if (playing !== 1'b0) $display("FAIL sat_done: got %b, expected 0", playing); else passed++;
    endtask

    task automatic test_overflow();
        rec_start = 1'b1;
        live_note = 32'h1;
        step(1);
        rec_start = 1'b0;
        step(7);
        live_note = 32'h2;
        step(8);
        live_note = 32'h4;
        step(8);
        live_note = 32'h8;
        step(1);
        total++; if (event_count !== 3'd3) $display("FAIL ovf_cnt3: got %0d, expected 3", event_count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL ovf_early: got %b, expected 0", overflow); else passed++;
        step(7);
        live_note = 32'h10;
        step(1);
        total++; if (event_count !== 3'd4) $display("FAIL ovf_cnt4: got %0d, expected 4", event_count); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b, expected 1", overflow); else passed++;
        total++; if (recording !== 1'b0) $display("FAIL ovf_rec: got %b, expected 0", recording); else passed++;
        live_note = 32'h0;
        step(1);
    endtask

    task automatic test_reset_mid_play();
        play_start = 1'b1;
        step(1);
        play_start = 1'b0;
        step(2);
        total++; if (note_out !== 32'h1) $display("FAIL ovfplay_ev0: got %h, expected 1", note_out); else passed++;
        step(15);
        total++; if (note_out !== 32'h8) $display("FAIL ovfplay_ev3: got %h, expected 8", note_out); else passed++;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        total++; if (note_out !== 32'h0) $display("FAIL rstplay_note: got %h, expected 0", note_out); else passed++;
        total++; if (playing !== 1'b0) $display("FAIL rstplay_playing: got %b, expected 0", playing); else passed++;
        total++; if (event_count !== 3'd0) $display("FAIL rstplay_cnt: got %0d, expected 0", event_count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rstplay_ovf: got %b, expected 0", overflow); else passed++;
    endtask

    initial begin
        reset      = 1'b1;
        live_note  = 32'h0;
        rec_start  = 1'b0;
        play_start = 1'b0;
        stop       = 1'b0;
        test_reset();
        test_passthrough();
        test_play_empty("empty0");
        test_record();
        test_playback();
        test_simultaneous();
        test_saturation();
        test_overflow();
        test_reset_mid_play();
        test_play_empty("empty1");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
